// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and constants for the register-file writeback arbiter
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

package wb_pkg;

    localparam int WB_DATA_W = `WORD_SIZE;

    // r0 is hard-wired zero in the register file; writes to it are dropped
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [4:0]           num;
        logic [WB_DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic [0:0] {
        WB_RUN   = 1'b0,
        WB_STALL = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - sync FIFO of writeback requests; WB_BYPASS_EN exposes all entries for forwarding
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  wb_req_t             push_req,
    input  logic                pop,
    output wb_req_t             head,
    output logic                full,
    output logic                empty
`ifdef WB_BYPASS_EN
    ,
    output logic [AW:0]         count,
    output logic [AW-1:0]       rd_idx,
    output wb_req_t [DEPTH-1:0] entries
`endif
);

    wb_req_t [DEPTH-1:0] mem;
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW:0]         cnt;

    // Storage needs no reset: only entries between the pointers are ever observed
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_req;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (cnt == (AW+1)'(DEPTH));
    assign empty = (cnt == '0);

`ifdef WB_BYPASS_EN
    assign count   = cnt;
    assign rd_idx  = rd_ptr;
    assign entries = mem;
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - merges WB-stage and long-latency writebacks onto one regfile write port; optional WB_BYPASS_EN
module regfile_wb_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_W     = WB_DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p_valid,
    input  logic [4:0]        p_num,
    input  logic [DATA_W-1:0] p_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [4:0]        s_num,
    input  logic [DATA_W-1:0] s_data,
    output logic              write_en,
    output logic [4:0]        write_num,
    output logic [DATA_W-1:0] write_data,
    output logic              pending,
    output logic              stall_req
`ifdef WB_BYPASS_EN
    ,
    input  logic [4:0]        byp_num,
    output logic              byp_hit,
    output logic [DATA_W-1:0] byp_data
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(STARVE_MAX + 1);

    wb_req_t       push_req;
    wb_req_t       head;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          p_win;
    logic          blocked;
    logic [CW-1:0] starve_cnt;
    wb_state_e     state;

`ifdef WB_BYPASS_EN
    logic [AW:0]              count;
    logic [AW-1:0]            rd_idx;
    wb_req_t [FIFO_DEPTH-1:0] entries;
    logic [AW-1:0]            idx;
`endif

    // Primary always wins; r0 writes from either side are swallowed here
    assign p_win    = p_valid && (p_num != REG_ZERO);
    assign push     = s_valid && s_ready && (s_num != REG_ZERO);
    assign pop      = !empty && !p_win;
    assign blocked  = !empty && p_win;
    assign push_req = '{num: s_num, data: s_data};
    assign s_ready  = !full;
    assign pending  = !empty;
    assign stall_req = (state == WB_STALL);

    wb_fifo #(
        .DEPTH    (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_req (push_req),
        .pop      (pop),
        .head     (head),
        .full     (full),
        .empty    (empty)
`ifdef WB_BYPASS_EN
        ,
        .count    (count),
        .rd_idx   (rd_idx),
        .entries  (entries)
`endif
    );

    // Registered write port: primary, else FIFO head, else idle with num/data held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_en   <= 1'b0;
            write_num  <= '0;
            write_data <= '0;
        end else if (p_win) begin
            write_en   <= 1'b1;
            write_num  <= p_num;
            write_data <= p_data;
        end else if (!empty) begin
            write_en   <= 1'b1;
            write_num  <= head.num;
            write_data <= head.data;
        end else begin
            write_en   <= 1'b0;
        end
    end

    // Starvation tracking: count blocked head cycles, stall once the limit is hit, release on pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            state      <= WB_RUN;
        end else begin
            if (pop || empty) begin
                starve_cnt <= '0;
            end else if (blocked && (starve_cnt != CW'(STARVE_MAX))) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
            case (state)
                WB_RUN:   if (blocked && (starve_cnt == CW'(STARVE_MAX - 1))) state <= WB_STALL;
                WB_STALL: if (pop) state <= WB_RUN;
                default:  state <= WB_RUN;
            endcase
        end
    end

`ifdef WB_BYPASS_EN
    // Forwarding search over live entries, oldest to youngest so the youngest match wins
    always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        idx      = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            idx = rd_idx + AW'(i);
            if (((AW+1)'(i) < count) && (byp_num != REG_ZERO) && (entries[idx].num == byp_num)) begin
                byp_hit  = 1'b1;
                byp_data = entries[idx].data;
            end
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        p_valid;
    logic [4:0]  p_num;
    logic [31:0] p_data;
    logic        s_valid;
    logic        s_ready;
    logic [4:0]  s_num;
    logic [31:0] s_data;
    logic        write_en;
    logic [4:0]  write_num;
    logic [31:0] write_data;
    logic        pending;
    logic        stall_req;
`ifdef WB_BYPASS_EN
    logic [4:0]  byp_num;
    logic        byp_hit;
    logic [31:0] byp_data;
`endif

    int checks;
    int errors;

    regfile_wb_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .p_valid    (p_valid),
        .p_num      (p_num),
        .p_data     (p_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_num      (s_num),
        .s_data     (s_data),
        .write_en   (write_en),
        .write_num  (write_num),
        .write_data (write_data),
        .pending    (pending),
        .stall_req  (stall_req)
`ifdef WB_BYPASS_EN
        ,
        .byp_num    (byp_num),
        .byp_hit    (byp_hit),
        .byp_data   (byp_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        p_valid = 1'b0;
        p_num   = '0;
        p_data  = '0;
        s_valid = 1'b0;
        s_num   = '0;
        s_data  = '0;
`ifdef WB_BYPASS_EN
        byp_num = '0;
`endif
        #12;
        check("rst_we", 32'(write_en), 32'd0);
        check("rst_num", 32'(write_num), 32'd0);
        check("rst_data", write_data, 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_stall", 32'(stall_req), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // primary write appears one edge later
        p_valid = 1'b1; p_num = 5'd5; p_data = 32'hDEADBEEF;
        tick();
        check("p_we", 32'(write_en), 32'd1);
        check("p_num", 32'(write_num), 32'd5);
        check("p_data", write_data, 32'hDEADBEEF);
        p_valid = 1'b0;
        tick();
        check("p_idle_we", 32'(write_en), 32'd0);
        check("p_idle_num_hold", 32'(write_num), 32'd5);

        // fill FIFO behind a busy primary, then drain in order (pointers wrap)
        p_valid = 1'b1; p_num = 5'd20; p_data = 32'hA0;
        for (int i = 1; i <= 4; i++) begin
            s_valid = 1'b1; s_num = 5'(i); s_data = 32'(i);
            tick();
            check("fill_p_num", 32'(write_num), 32'd20);
            check("fill_s_ready", 32'(s_ready), (i == 4) ? 32'd0 : 32'd1);
        end
        check("fill_pending", 32'(pending), 32'd1);
        s_valid = 1'b0; p_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("drain_we", 32'(write_en), 32'd1);
            check("drain_num", 32'(write_num), 32'(i));
            check("drain_data", write_data, 32'(i));
            check("drain_pending", 32'(pending), (i == 4) ? 32'd0 : 32'd1);
        end
        tick();
        check("drain_idle_we", 32'(write_en), 32'd0);

        // starvation: r7 blocked by primary for 8 cycles
        p_valid = 1'b1; p_num = 5'd11; p_data = 32'hB;
        s_valid = 1'b1; s_num = 5'd7; s_data = 32'h77;
        tick();
        s_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check("starve_stall", 32'(stall_req), (i == 8) ? 32'd1 : 32'd0);
        end
        p_valid = 1'b0;
        tick();
        check("starve_pop_we", 32'(write_en), 32'd1);
        check("starve_pop_num", 32'(write_num), 32'd7);
        check("starve_pop_data", write_data, 32'h77);
        check("starve_release", 32'(stall_req), 32'd0);
        check("starve_pending", 32'(pending), 32'd0);

        // r0 requests on both channels are discarded
        p_valid = 1'b1; p_num = 5'd0; p_data = 32'h55;
        s_valid = 1'b1; s_num = 5'd0; s_data = 32'h66;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("r0_we", 32'(write_en), 32'd0);
            check("r0_pending", 32'(pending), 32'd0);
            check("r0_s_ready", 32'(s_ready), 32'd1);
        end
        p_valid = 1'b0; s_valid = 1'b0;

        // no same-cycle bypass from an empty FIFO
        s_valid = 1'b1; s_num = 5'd6; s_data = 32'h600;
        tick();
        s_valid = 1'b0;
        check("nobyp_we", 32'(write_en), 32'd0);
        check("nobyp_pending", 32'(pending), 32'd1);
        tick();
        check("nobyp_pop_we", 32'(write_en), 32'd1);
        check("nobyp_pop_num", 32'(write_num), 32'd6);
        check("nobyp_pop_data", write_data, 32'h600);

        // async reset with three entries queued
        p_valid = 1'b1; p_num = 5'd12; p_data = 32'hC;
        for (int i = 1; i <= 3; i++) begin
            s_valid = 1'b1; s_num = 5'(i + 20); s_data = 32'(i);
            tick();
        end
        s_valid = 1'b0;
        check("prerst_pending", 32'(pending), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_we", 32'(write_en), 32'd0);
        check("arst_pending", 32'(pending), 32'd0);
        check("arst_s_ready", 32'(s_ready), 32'd1);
        p_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("postrst_we", 32'(write_en), 32'd0);
            check("postrst_pending", 32'(pending), 32'd0);
        end

`ifdef WB_BYPASS_EN
        // forwarding search: youngest r9 entry wins
        p_valid = 1'b1; p_num = 5'd13; p_data = 32'hD;
        s_valid = 1'b1; s_num = 5'd9; s_data = 32'h11;
        tick();
        s_data = 32'h22;
        tick();
        s_valid = 1'b0;
        byp_num = 5'd9;
        #1;
        check("byp_hit9", 32'(byp_hit), 32'd1);
        check("byp_data9", byp_data, 32'h22);
        byp_num = 5'd3;
        #1;
        check("byp_hit3", 32'(byp_hit), 32'd0);
        check("byp_data3", byp_data, 32'd0);
        byp_num = 5'd0;
        #1;
        check("byp_hit0", 32'(byp_hit), 32'd0);
        p_valid = 1'b0;
        tick();
        tick();
        tick();
        check("byp_drained", 32'(pending), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
